apb_master_bridge: RTL and testbench
====================================

APB_MASTER_BRIDGE -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL have no parameters; the address map and slave count (4) are fixed.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 PCLK  input  1  clock; all state updates on the rising edge.
REQ-004 PRESET  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-005 transfer  input  1  request pulse from the host side; sampled on the rising edge.
REQ-006 write  input  1  request direction; 1 = write, 0 = read.
REQ-007 addr  input  32  request address.
REQ-008 wdata  input  32  request write data.
REQ-009 ready  output  1  transfer-complete strobe to the host side.
REQ-010 rdata  output  32  read data to the host side, valid while ready=1.
REQ-011 PADDR, PWDATA  output  32 each  APB address and write data.
REQ-012 PWRITE, PENABLE  output  1 each  APB direction and access phase.
REQ-013 PSEL0..PSEL3  output  1 each  one-hot slave selects.
REQ-014 PRDATA0..PRDATA3  input  32 each  slave read data.
REQ-015 PREADY0..PREADY3  input  1 each  slave ready.

Function
REQ-016 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-017 IDLE: on a rising edge with transfer=1, the block SHALL latch addr, write and wdata into PADDR, PWRITE and PWDATA and move to SETUP; otherwise it SHALL stay in IDLE.
REQ-018 SETUP: the decoded PSELn SHALL be 1, PENABLE=0, and the next state SHALL always be ACCESS, lasting exactly one cycle.
REQ-019 ACCESS: the decoded PSELn SHALL be 1 and PENABLE=1; the state SHALL hold while the selected PREADYn=0.
REQ-020 When the selected PREADYn=1 in ACCESS, the next state SHALL be SETUP if transfer=1 (re-latching the request), else IDLE.
REQ-021 Decode SHALL use addr[31:12]: 0x10000 selects PSEL0, 0x10001 PSEL1, 0x10002 PSEL2, 0x10003 PSEL3.
REQ-022 Any other address SHALL assert no PSELn; the access SHALL complete in its first ACCESS cycle with ready=1 and rdata=0.
REQ-023 ready SHALL be combinational: it SHALL equal the selected PREADYn in ACCESS and SHALL be 0 in IDLE and SETUP.
REQ-024 rdata SHALL be combinational: it SHALL equal the selected PRDATAn while in ACCESS, and 0 otherwise.
REQ-025 In IDLE, all PSELn and PENABLE SHALL be 0, and PADDR, PWRITE and PWDATA SHALL hold their last latched values.
REQ-026 PADDR, PWRITE and PWDATA SHALL NOT change from SETUP through completion of ACCESS; transfer, addr, write and wdata changes during that time SHALL be ignored.
REQ-027 A transfer pulse arriving while in SETUP, or in ACCESS with PREADYn=0, SHALL be dropped; the host waits for ready before issuing the next request.
REQ-028 At most one PSELn SHALL be high in any cycle.

Reset
REQ-029 While PRESET=0, the state SHALL be IDLE and all outputs SHALL be 0: PADDR, PWDATA, PWRITE, PENABLE, PSEL0..3, ready and rdata.
REQ-030 Reset asserted mid-transfer SHALL abort it immediately, dropping PSEL and PENABLE asynchronously; the block SHALL restart in IDLE with no pending request.

Verification
REQ-031 Write slave0: transfer pulse with write=1, addr=0x1000_0000, wdata=10, PREADY0=1 -> SETUP cycle with PSEL0=1, PENABLE=0, PADDR=0x1000_0000, PWDATA=10, PWRITE=1; next cycle ACCESS with PENABLE=1 and ready=1; then IDLE.
REQ-032 Write slaves 1-3: addr 0x1000_1000, 0x1000_2000 and 0x1000_3000 with wdata 11, 12, 13 -> only PSEL1, PSEL2 and PSEL3 respectively assert; each completes in 2 cycles.
REQ-033 Read slave0 after the write: write=0, addr=0x1000_0000, PRDATA0=10 -> ready=1 with rdata=10 in ACCESS.
REQ-034 Wait states: PREADY1 held low for 3 ACCESS cycles -> PENABLE, PSEL1 and PADDR stay stable for 4 ACCESS cycles; ready=1 only in the last.
REQ-035 Unmapped address 0x2000_0000 -> no PSELn asserted, ready=1 in the first ACCESS cycle, rdata=0.
REQ-036 Reset mid-transfer: PRESET driven 0 during ACCESS -> all outputs 0 immediately; a fresh request after release completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB master bridge: turns single host transfer requests into APB SETUP/ACCESS
// sequences towards four fixed-address slaves.
module apb_master_bridge (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned NSLV = 4;
    // addr[31:14] of the 16 KiB window holding slaves 0x10000..0x10003 (addr[31:12])
    localparam logic [17:0] SLV_BASE = 18'h04000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              load_c;
    logic [AW-1:0]     paddr_d;
    logic [NSLV-1:0]   psel_q, psel_d;
    logic              penable_d;
    logic              sel_ready_c;
    logic [DW-1:0]     sel_rdata_c;

    assign PSEL0 = psel_q[0];
    assign PSEL1 = psel_q[1];
    assign PSEL2 = psel_q[2];
    assign PSEL3 = psel_q[3];

    // Selected slave response; an unmapped access completes at once with zero data
    always_comb begin
        sel_ready_c = 1'b1;
        sel_rdata_c = '0;
        case (psel_q)
            4'b0001: begin sel_ready_c = PREADY0; sel_rdata_c = PRDATA0; end
            4'b0010: begin sel_ready_c = PREADY1; sel_rdata_c = PRDATA1; end
            4'b0100: begin sel_ready_c = PREADY2; sel_rdata_c = PRDATA2; end
            4'b1000: begin sel_ready_c = PREADY3; sel_rdata_c = PRDATA3; end
            default: ;
        endcase
    end

    assign ready = (state_q == ACCESS) && sel_ready_c;
    assign rdata = (state_q == ACCESS) ? sel_rdata_c : '0;

    // Next state, request latch enable and next-cycle APB selects
    always_comb begin
        state_d   = state_q;
        load_c    = 1'b0;
        paddr_d   = PADDR;
        psel_d    = '0;
        penable_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    load_c  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (sel_ready_c) begin
                    if (transfer) begin
                        load_c  = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_c) begin
            paddr_d = addr;
        end
        if ((state_d != IDLE) && (paddr_d[AW-1:14] == SLV_BASE)) begin
            psel_d[paddr_d[13:12]] = 1'b1;
        end
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q <= IDLE;
            PADDR   <= '0;
            PWDATA  <= '0;
            PWRITE  <= 1'b0;
            psel_q  <= '0;
            PENABLE <= 1'b0;
        end else begin
            state_q <= state_d;
            psel_q  <= psel_d;
            PENABLE <= penable_d;
            if (load_c) begin
                PADDR  <= addr;
                PWDATA <= wdata;
                PWRITE <= write;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: the bench plays host and all four slaves,
// predicting each transaction's APB phases from its address and wait count.
module tb_apb_master_bridge;

    logic        PCLK;
    logic        PRESET;
    logic        transfer;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL0, PSEL1, PSEL2, PSEL3;
    logic [31:0] prdata [4];
    logic        pready [4];

    apb_master_bridge dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .rdata    (rdata),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PSEL0    (PSEL0),
        .PSEL1    (PSEL1),
        .PSEL2    (PSEL2),
        .PSEL3    (PSEL3),
        .PRDATA0  (prdata[0]),
        .PRDATA1  (prdata[1]),
        .PRDATA2  (prdata[2]),
        .PRDATA3  (prdata[3]),
        .PREADY0  (pready[0]),
        .PREADY1  (pready[1]),
        .PREADY2  (pready[2]),
        .PREADY3  (pready[3])
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          waits;
        bit          b2b;
    } req_t;

    int n_cmp = 0;
    int n_err = 0;
    bit latched = 1'b0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] wr_addrs [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Slave index of an address, -1 when it falls outside the four 4 KiB slave pages
    function automatic int slave_of(input logic [31:0] a);
        logic [19:0] page;
        page = a[31:12];
        if (page >= 20'h10000 && page <= 20'h10003) return int'(page - 20'h10000);
        return -1;
    endfunction

    function automatic logic [31:0] psel_vec();
        return {28'd0, PSEL3, PSEL2, PSEL1, PSEL0};
    endfunction

    function automatic logic [31:0] onehot(input int s);
        logic [31:0] v;
        v = '0;
        if (s >= 0) v[s] = 1'b1;
        return v;
    endfunction

    task automatic drive_slaves(input int sel, input logic rdy, input logic [31:0] rd);
        for (int i = 0; i < 4; i++) begin
            if (i == sel) begin
                pready[i] = rdy;
                prdata[i] = rd;
            end else begin
                pready[i] = 1'($urandom_range(0, 1));
                prdata[i] = $urandom;
            end
        end
    endtask

    task automatic junk_host(input bit allow_xfer);
        transfer = allow_xfer ? 1'($urandom_range(0, 1)) : 1'b0;
        write    = 1'($urandom_range(0, 1));
        addr     = $urandom;
        wdata    = $urandom;
    endtask

    task automatic check_bus(input string ph, input req_t r, input int s, input logic en,
                             input logic rdy, input logic [31:0] rd);
        check({ph, ".psel"},    psel_vec(),   en === 1'bx ? 32'd0 : onehot(s));
        check({ph, ".paddr"},   PADDR,        r.a);
        check({ph, ".pwdata"},  PWDATA,       r.d);
        check({ph, ".pwrite"},  32'(PWRITE),  32'(r.w));
        check({ph, ".penable"}, 32'(PENABLE), 32'(en));
        check({ph, ".ready"},   32'(ready),   32'(rdy));
        check({ph, ".rdata"},   rdata,        rd);
    endtask

    // One complete transaction; optionally issues the next request in the final ACCESS cycle
    task automatic xfer(input req_t r, input bit chain, input req_t nx);
        int          s;
        int          nacc;
        bit          last;
        logic [31:0] sel_rd;
        s = slave_of(r.a);
        if (!latched) begin
            transfer = 1'b1; write = r.w; addr = r.a; wdata = r.d;
            drive_slaves(-1, 1'b0, 32'd0);
            @(posedge PCLK);
        end
        if (s < 0)        sel_rd = 32'd0;
        else if (!r.w)    sel_rd = mem.exists(r.a) ? mem[r.a] : 32'd0;
        else              sel_rd = $urandom;

        @(negedge PCLK);
        junk_host(1'b1);
        drive_slaves(s, 1'($urandom_range(0, 1)), $urandom);
        #1 check_bus("setup", r, s, 1'b0, 1'b0, 32'd0);
        @(posedge PCLK);

        nacc = (s < 0) ? 1 : r.waits + 1;
        for (int i = 0; i < nacc; i++) begin
            @(negedge PCLK);
            last = (i == nacc - 1);
            drive_slaves(s, last, sel_rd);
            if (last && chain) begin
                transfer = 1'b1; write = nx.w; addr = nx.a; wdata = nx.d;
            end else begin
                junk_host(!last);
            end
            #1 check_bus("access", r, s, 1'b1, last, sel_rd);
            @(posedge PCLK);
        end
        if (r.w && s >= 0) begin
            mem[r.a] = r.d;
            wr_addrs.push_back(r.a);
        end
        latched = chain;
        if (!chain) begin
            @(negedge PCLK);
            junk_host(1'b0);
            drive_slaves(-1, 1'b0, 32'd0);
            #1 check_bus("idle", r, -1, 1'b0, 1'b0, 32'd0);
        end
    endtask

    task automatic run_list(input req_t q[$]);
        req_t none;
        none = '{w: 1'b0, a: 32'd0, d: 32'd0, waits: 0, b2b: 1'b0};
        for (int k = 0; k < q.size(); k++) begin
            if (k + 1 < q.size() && q[k+1].b2b) xfer(q[k], 1'b1, q[k+1]);
            else                                xfer(q[k], 1'b0, none);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".psel"},    psel_vec(),   32'd0);
        check({tag, ".paddr"},   PADDR,        32'd0);
        check({tag, ".pwdata"},  PWDATA,       32'd0);
        check({tag, ".pwrite"},  32'(PWRITE),  32'd0);
        check({tag, ".penable"}, 32'(PENABLE), 32'd0);
        check({tag, ".ready"},   32'(ready),   32'd0);
        check({tag, ".rdata"},   rdata,        32'd0);
    endtask

    function automatic req_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input int waits, input bit b2b);
        req_t r;
        r.w = w; r.a = a; r.d = d; r.waits = waits; r.b2b = b2b;
        return r;
    endfunction

    initial begin
        req_t dq[$];
        req_t rq[$];
        req_t r;
        int   s;

        PRESET = 1'b0;
        transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        drive_slaves(-1, 1'b0, 32'd0);
        #12 check_all_zero("reset");
        @(negedge PCLK);
        PRESET = 1'b1;

        // Directed: writes to each slave, read-back, wait states, unmapped, back-to-back
        dq.push_back(mk(1'b1, 32'h1000_0000, 32'd10, 0, 1'b0));
        dq.push_back(mk(1'b1, 32'h1000_1000, 32'd11, 0, 1'b0));
        dq.push_back(mk(1'b1, 32'h1000_2000, 32'd12, 0, 1'b0));
        dq.push_back(mk(1'b1, 32'h1000_3000, 32'd13, 0, 1'b0));
        dq.push_back(mk(1'b0, 32'h1000_0000, 32'd0,  0, 1'b0));
        dq.push_back(mk(1'b0, 32'h1000_1000, 32'd0,  3, 1'b0));
        dq.push_back(mk(1'b0, 32'h2000_0000, 32'd0,  2, 1'b0));
        dq.push_back(mk(1'b1, 32'h2000_0000, 32'h55, 0, 1'b0));
        dq.push_back(mk(1'b0, 32'h1000_3000, 32'd0,  1, 1'b1));
        dq.push_back(mk(1'b0, 32'h1000_2000, 32'd0,  0, 1'b1));
        run_list(dq);

        // Reset in the middle of an ACCESS with the slave stalling
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_1004; wdata = 32'hdead_beef;
        @(posedge PCLK);
        @(negedge PCLK);
        junk_host(1'b0);
        @(posedge PCLK);
        @(negedge PCLK);
        drive_slaves(1, 1'b0, 32'h1234_5678);
        #1 check("pre_reset.penable", 32'(PENABLE), 32'd1);
        PRESET = 1'b0;
        #1 check_all_zero("mid_reset");
        @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b1;
        latched = 1'b0;
        #1 check_all_zero("post_reset");
        dq.delete();
        dq.push_back(mk(1'b1, 32'h1000_1004, 32'h0000_00aa, 1, 1'b0));
        dq.push_back(mk(1'b0, 32'h1000_1004, 32'd0, 0, 1'b0));
        run_list(dq);

        // Randomized traffic, mixing read-back of earlier writes
        for (int k = 0; k < 60; k++) begin
            s = $urandom_range(0, 4);
            if (s == 4) begin
                r.a = $urandom;
                if (slave_of(r.a) >= 0) r.a[31] = ~r.a[31];
            end else begin
                r.a = {20'h10000 + 20'(s), 12'($urandom)};
            end
            r.w = 1'($urandom_range(0, 1));
            if (!r.w && wr_addrs.size() > 0 && $urandom_range(0, 1) == 1)
                r.a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
            r.d     = $urandom;
            r.waits = $urandom_range(0, 3);
            r.b2b   = ($urandom_range(0, 2) == 0);
            rq.push_back(r);
        end
        run_list(rq);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
